// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } arb_state_t;

  // Index that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: the first requester at or above rr_ptr
// wins, wrapping past N-1 back to 0. Kept generic for reuse on the RX side.
module rr_arbiter_n
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] cand_s;

  // Scan the ring starting at rr_ptr and keep the first active request.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    cand_s     = '0;
    for (int k = 0; k < N; k++) begin
      cand_s             = IDX_W'((int'(rr_ptr) + k) % N);
      hit_s              = !found_s && req[cand_s];
      winner_oh[cand_s]  = winner_oh[cand_s] | hit_s;
      winner_idx         = hit_s ? cand_s : winner_idx;
      found_s            = found_s | hit_s;
    end
  end

  assign valid = found_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte sources. Grants round-robin, launches
// the owner's byte with a one-cycle tx_en, follows tx_busy to the end of the
// stop bit and returns a one-cycle done to the owner.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                      clk_baud,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_en,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      err_tout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t          state_r, state_nxt_s;
  logic [NUM_REQ-1:0]  grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0]  done_r, done_nxt_s;
  logic                tx_en_r, tx_en_nxt_s;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_nxt_s;
  logic                err_r, err_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]    owner_r, owner_nxt_s;
  logic [IDX_W-1:0]    ptr_after_owner_s;
  logic [NUM_REQ-1:0]  arb_req_s;
  logic [NUM_REQ-1:0]  win_oh_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                win_valid_s;

  // The requester that is just being told done still holds req this cycle;
  // keep it out of the arbitration so it is not served twice.
  assign arb_req_s         = req & ~done_r;
  assign ptr_after_owner_s = IDX_W'(rr_next(int'(owner_r), NUM_REQ));

  rr_arbiter_n #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (arb_req_s),
    .rr_ptr     (rr_ptr_r),
    .winner_oh  (win_oh_s),
    .winner_idx (win_idx_s),
    .valid      (win_valid_s)
  );

  // Next-state and next-output decode for the launch/track sequence.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    done_nxt_s    = '0;
    tx_en_nxt_s   = 1'b0;
    tx_data_nxt_s = tx_data_r;
    err_nxt_s     = err_r;
    cnt_nxt_s     = cnt_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    owner_nxt_s   = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && !tx_busy) begin
          state_nxt_s   = ST_LAUNCH;
          grant_nxt_s   = win_oh_s;
          owner_nxt_s   = win_idx_s;
          tx_data_nxt_s = req_data[{win_idx_s, 3'b000} +: BYTE_W];
          tx_en_nxt_s   = 1'b1;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        // Restart the count; it measures cycles since LAUNCH, which is the first.
        state_nxt_s = ST_WAIT_BUSY;
        cnt_nxt_s   = CNT_W'(1);
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r + CNT_W'(1) == CNT_W'(BUSY_TIMEOUT)) begin
          state_nxt_s  = ST_IDLE;
          err_nxt_s    = 1'b1;
          done_nxt_s   = grant_r;
          grant_nxt_s  = '0;
          rr_ptr_nxt_s = ptr_after_owner_s;
        end else begin
          cnt_nxt_s    = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s  = ST_IDLE;
          done_nxt_s   = grant_r;
          grant_nxt_s  = '0;
          rr_ptr_nxt_s = ptr_after_owner_s;
        end else begin
          state_nxt_s  = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_baud) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output, ownership, pointer and timeout registers.
  always_ff @(posedge clk_baud) begin
    if (!rst_n) begin
      grant_r   <= '0;
      done_r    <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
      err_r     <= 1'b0;
      cnt_r     <= '0;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
    end else begin
      grant_r   <= grant_nxt_s;
      done_r    <= done_nxt_s;
      tx_en_r   <= tx_en_nxt_s;
      tx_data_r <= tx_data_nxt_s;
      err_r     <= err_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      owner_r   <= owner_nxt_s;
    end
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign tx_en    = tx_en_r;
  assign tx_data  = tx_data_r;
  assign err_tout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx (busy two cycles after en,
// start + 8 data LSB first + stop), a line decoder, and a transaction-level
// round-robin model checked every cycle.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TOUT = 4;

  logic        clk_baud = 1'b0;
  logic        rst_n    = 1'b0;
  logic [3:0]  req      = 4'b0000;
  logic [7:0]  data_reg [4];
  logic [31:0] req_data;
  logic [3:0]  grant, done;
  logic        tx_en, err_tout, tx_busy_s;
  logic [7:0]  tx_data;
  bit          stub_mode = 1'b0;

  always #5 clk_baud = ~clk_baud;

  assign req_data  = {data_reg[3], data_reg[2], data_reg[1], data_reg[0]};

  // uart_tx behavioural model
  logic       u_busy  = 1'b0;
  logic       u_line  = 1'b1;
  logic [3:0] u_phase = 4'd0;
  logic [7:0] u_sh    = 8'h00;

  assign tx_busy_s = stub_mode ? 1'b0 : u_busy;

  always @(posedge clk_baud) begin
    if (u_phase == 4'd0) begin
      if (tx_en && !stub_mode) begin
        u_phase <= 4'd1;
        u_sh    <= tx_data;
      end
    end else if (u_phase == 4'd1) begin
      u_busy  <= 1'b1;
      u_line  <= 1'b0;
      u_phase <= 4'd2;
    end else if (u_phase <= 4'd9) begin
      u_line  <= u_sh[0];
      u_sh    <= {1'b0, u_sh[7:1]};
      u_phase <= u_phase + 4'd1;
    end else if (u_phase == 4'd10) begin
      u_line  <= 1'b1;
      u_phase <= 4'd11;
    end else begin
      u_busy  <= 1'b0;
      u_phase <= 4'd0;
    end
  end

  // line decoder
  logic       rx_act = 1'b0;
  logic [3:0] rx_n   = 4'd0;
  logic [7:0] rx_b   = 8'h00;
  int         rx_frame_err = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk_baud) begin
    if (!rx_act) begin
      if (u_line == 1'b0) begin
        rx_act <= 1'b1;
        rx_n   <= 4'd0;
      end
    end else if (rx_n < 4'd8) begin
      rx_b <= {u_line, rx_b[7:1]};
      rx_n <= rx_n + 4'd1;
    end else begin
      rx_act <= 1'b0;
      if (u_line !== 1'b1) rx_frame_err <= rx_frame_err + 1;
      rx_q.push_back(rx_b);
    end
  end

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TOUT)) dut (
    .clk_baud (clk_baud),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy_s),
    .err_tout (err_tout)
  );

  // scoreboard / model state
  int         total = 0, bad = 0;
  int         cyc = 0, done_cnt = 0, last_done_cyc = 0;
  int         rr_m = 0, owner_m = 0;
  bit         owned_m = 1'b0, prev_en = 1'b0;
  logic [3:0] hold_mask = 4'b0000;
  logic [3:0] arb_req;
  logic [7:0] arb_data [4];
  logic [7:0] cur_byte;
  int         order_q [$];
  logic [7:0] exp_bytes [$];

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp_seq;
    int          n;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock: record what arbitration sees, step, then check all outputs.
  task automatic tick();
    bit rst_seen;
    int w;
    arb_req = req & ~done;
    for (int i = 0; i < N; i++) arb_data[i] = data_reg[i];
    rst_seen = !rst_n;
    @(posedge clk_baud);
    #1;
    cyc++;
    if (rst_seen) begin
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_err", err_tout, 0);
      owned_m = 1'b0;
      rr_m    = 0;
      prev_en = 1'b0;
    end else begin
      if (done != 4'b0000) begin
        chk("done_owner", done, owned_m ? (32'd1 << owner_m) : 32'd0);
        chk("grant_clear_on_done", grant, 0);
        if (owned_m) rr_m = (owner_m + 1) % N;
        owned_m       = 1'b0;
        done_cnt++;
        last_done_cyc = cyc;
      end else if (tx_en) begin
        w = pick(arb_req, rr_m);
        chk("en_while_owned", owned_m, 0);
        chk("en_pulse_width", prev_en, 0);
        chk("en_has_winner", (w >= 0), 1);
        if (w >= 0) begin
          chk("grant_winner", grant, 32'd1 << w);
          chk("tx_data_launch", tx_data, arb_data[w]);
          owned_m  = 1'b1;
          owner_m  = w;
          cur_byte = arb_data[w];
          order_q.push_back(w);
          if (!stub_mode) exp_bytes.push_back(arb_data[w]);
        end
      end else if (owned_m) begin
        chk("grant_held", grant, 32'd1 << owner_m);
        chk("tx_data_stable", tx_data, cur_byte);
      end else begin
        chk("grant_idle", grant, 0);
      end
      prev_en = tx_en;
    end
    for (int i = 0; i < N; i++) begin
      if (done[i] && !hold_mask[i]) req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, done_cnt, target);
  endtask

  task automatic wait_en(input int budget, input string name);
    int k = 1;
    tick();
    while (!tx_en && k < budget) begin
      tick();
      k++;
    end
    chk(name, tx_en, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((u_busy || u_phase != 4'd0 || rx_act) && k < budget) begin
      tick();
      k++;
    end
    chk("uart_idle", {u_busy, rx_act, u_phase}, 0);
  endtask

  task automatic check_bytes(input string name);
    chk({name, "_count"}, rx_q.size(), exp_bytes.size());
    for (int k = 0; k < rx_q.size() && k < exp_bytes.size(); k++) chk(name, rx_q[k], exp_bytes[k]);
    rx_q.delete();
    exp_bytes.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, l_cyc, e_cyc, k;
    logic [31:0] packed_v;
    int pend [4];
    int max_wait;

    for (int i = 0; i < N; i++) data_reg[i] = 8'h00;
    vecs[0] = '{4'b0100, 32'h004E0000, 32'h0000004E, 1};
    vecs[1] = '{4'b1111, 32'h44434241, 32'h41424344, 4};
    vecs[2] = '{4'b1010, 32'hA300A100, 32'h0000A1A3, 2};
    vecs[3] = '{4'b0101, 32'h00C200C0, 32'h0000C0C2, 2};
    vecs[4] = '{4'b1001, 32'h5A0000A5, 32'h0000A55A, 2};
    vecs[5] = '{4'b1000, 32'hFF000000, 32'h000000FF, 1};
    vecs[6] = '{4'b0011, 32'h00000100, 32'h00000001, 2};

    // table: all requests raised together right after reset (pointer at 0)
    for (int v = 0; v < 7; v++) begin
      do_reset();
      rx_q.delete();
      exp_bytes.delete();
      for (int i = 0; i < N; i++) data_reg[i] = vecs[v].data[8*i +: 8];
      base = done_cnt;
      req  = vecs[v].mask;
      wait_done(base + vecs[v].n, vecs[v].n * 20 + 40, "tbl_done_count");
      wait_idle(40);
      packed_v = 32'h0;
      foreach (rx_q[q]) packed_v = (packed_v << 8) | {24'h0, rx_q[q]};
      chk("tbl_byte_count", rx_q.size(), vecs[v].n);
      chk("tbl_byte_seq", packed_v, vecs[v].exp_seq);
      chk("tbl_err", err_tout, 0);
      chk("tbl_frame", rx_frame_err, 0);
      check_bytes("tbl_bytes");
    end

    // fairness: 0 and 3 hold req for six bytes
    do_reset();
    order_q.delete();
    data_reg[0] = 8'h10;
    data_reg[3] = 8'h13;
    hold_mask   = 4'b1001;
    base        = done_cnt;
    req         = 4'b1001;
    wait_done(base + 6, 200, "fair_done_count");
    req       = 4'b0000;
    hold_mask = 4'b0000;
    wait_idle(40);
    packed_v = 32'h0;
    foreach (order_q[q]) packed_v = (packed_v << 4) | 32'(order_q[q]);
    chk("fair_grant_count", order_q.size(), 6);
    chk("fair_order", packed_v, 32'h00030303);
    check_bytes("fair_bytes");

    // drop: req[1] released three cycles after grant
    do_reset();
    data_reg[1] = 8'h5C;
    base        = done_cnt;
    req         = 4'b0010;
    wait_en(10, "drop_launch");
    tick(); tick(); tick();
    req[1] = 1'b0;
    wait_done(base + 1, 40, "drop_done");
    wait_idle(40);
    chk("drop_byte_count", rx_q.size(), 1);
    check_bytes("drop_bytes");

    // timeout: busy never rises
    do_reset();
    stub_mode   = 1'b1;
    data_reg[0] = 8'h77;
    base        = done_cnt;
    req         = 4'b0001;
    wait_en(10, "tout_launch");
    l_cyc  = cyc;
    req[0] = 1'b0;
    k = 0;
    while (!err_tout && k < 20) begin
      tick();
      k++;
    end
    e_cyc = cyc;
    chk("tout_err_rise", err_tout, 1);
    chk("tout_latency", e_cyc - l_cyc, TOUT);
    chk("tout_done_count", done_cnt, base + 1);
    chk("tout_done_cycle", last_done_cyc - l_cyc, TOUT);
    tick(); tick(); tick();
    chk("tout_err_sticky", err_tout, 1);
    stub_mode   = 1'b0;
    data_reg[1] = 8'h31;
    req         = 4'b0010;
    wait_done(base + 2, 40, "tout_recover_done");
    wait_idle(40);
    chk("tout_err_sticky2", err_tout, 1);
    check_bytes("tout_bytes");

    // reset while the byte is on the line
    do_reset();
    data_reg[2] = 8'h96;
    base        = done_cnt;
    req         = 4'b0100;
    wait_en(10, "rst_launch");
    for (int i = 0; i < 5; i++) tick();
    chk("rst_mid_busy", u_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_no_done", done_cnt, base);
    wait_done(base + 1, 60, "rst_reserve_done");
    wait_idle(40);
    check_bytes("rst_bytes");

    // random traffic
    do_reset();
    max_wait = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int t = 0; t < 2500; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !done[i] && $urandom_range(0, 7) == 0) begin
          data_reg[i] = 8'($urandom);
          req[i]      = 1'b1;
        end
      end
      if (owned_m && !tx_en && $urandom_range(0, 3) == 0) data_reg[owner_m] = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req[i] && !(owned_m && owner_m == i)) pend[i]++;
        else pend[i] = 0;
        if (pend[i] > max_wait) max_wait = pend[i];
      end
    end
    k = 0;
    while (req != 4'b0000 && k < 400) begin
      tick();
      k++;
    end
    chk("rand_drain", req, 0);
    wait_idle(40);
    chk("rand_max_wait", (max_wait <= 70), 1);
    chk("rand_err", err_tout, 0);
    chk("rand_frame", rx_frame_err, 0);
    check_bytes("rand_bytes");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
